// File: rtl/subtractor_pkg.sv
// Shared types and the full-subtractor borrow equation for subtractor_serial.
package subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic sub_borrow(input logic a, input logic b, input logic br);
    return (~a & b) | (~(a ^ b) & br);
  endfunction

endpackage

// File: rtl/subtractor_1bit.sv
// Combinational 1-bit full subtractor: diff = a - b - borrow_in.
module subtractor_1bit
  import subtractor_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic borrow_in,
  output logic diff,
  output logic borrow_out
);

  assign diff       = a ^ b ^ borrow_in;
  assign borrow_out = sub_borrow(a, b, borrow_in);

endmodule

// File: rtl/subtractor_serial.sv
// Bit-serial a - b - borrow_in, LSB first, one bit per clock through a single cell.
// Define SUBTRACTOR_ASSERT_EN to compile in simulation-only result/handshake assertions.
module subtractor_serial
  import subtractor_pkg::*;
#(
  parameter int BIT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic                 borrow_in,
  output logic                 busy,
  output logic                 done,
  output logic [BIT_WIDTH-1:0] diff,
  output logic                 underflow
);

  localparam int CW = $clog2(BIT_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(BIT_WIDTH - 1);

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [BIT_WIDTH-1:0] a_sr, b_sr;
  logic                 br;
  logic                 d_bit, br_nxt;

  subtractor_1bit u_cell (
    .a          (a_sr[0]),
    .b          (b_sr[0]),
    .borrow_in  (br),
    .diff       (d_bit),
    .borrow_out (br_nxt)
  );

  // underflow gets its own flop so it holds the last result while br is reloaded at start
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      a_sr      <= '0;
      b_sr      <= '0;
      br        <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      diff      <= '0;
      underflow <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            br    <= borrow_in;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          diff <= {d_bit, diff[BIT_WIDTH-1:1]};
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          br   <= br_nxt;
          cnt  <= cnt + CW'(1);
          if (cnt == LAST) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            underflow <= br_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SUBTRACTOR_ASSERT_EN
  logic [BIT_WIDTH-1:0] a_cap, b_cap;
  logic                 bi_cap;

  always @(posedge clk) begin
    if (n_rst && start && (state == IDLE || state == DONE)) begin
      assert (!$isunknown({a, b, borrow_in}))
        else $error("subtractor_serial: X/Z operand at start");
      a_cap  <= a;
      b_cap  <= b;
      bi_cap <= borrow_in;
    end
    if (n_rst && done)
      assert ({underflow, diff} ==
              ({1'b0, a_cap} - {1'b0, b_cap} - (BIT_WIDTH + 1)'(bi_cap)))
        else $error("subtractor_serial: result does not match captured operands");
    assert (!(done && busy))
      else $error("subtractor_serial: done and busy both high");
  end
`endif

endmodule

// File: tb/tb_subtractor_serial.sv
// Directed bench for subtractor_serial (BIT_WIDTH=4) with hand-computed results.
module tb_subtractor_serial;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       start;
  logic [3:0] a, b;
  logic       borrow_in;
  logic       busy, done, underflow;
  logic [3:0] diff;

  int checks = 0;
  int errors = 0;

  subtractor_serial #(.BIT_WIDTH(4)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .borrow_in (borrow_in),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Call right after driving operands/start at a negedge; returns at the negedge of the done cycle.
  task automatic wait_done(input string tag, input logic [3:0] ed, input logic eu, input bit hold);
    int k;
    int nb;
    @(negedge clk);
    k  = 1;
    nb = 0;
    if (!hold) start = 1'b0;
    while (!done && k < 20) begin
      nb += int'(busy);
      if (hold) begin
        a = a + 4'd3;
        b = b + 4'd5;
        borrow_in = ~borrow_in;
      end
      @(negedge clk);
      k++;
    end
    chk({tag, " latency"}, k, 5);
    chk({tag, " busy_cycles"}, nb, 4);
    chk({tag, " done"}, done, 1);
    chk({tag, " busy_in_done"}, busy, 0);
    chk({tag, " diff"}, diff, ed);
    chk({tag, " underflow"}, underflow, eu);
  endtask

  task automatic launch(input logic [3:0] av, input logic [3:0] bv, input logic bi);
    a = av;
    b = bv;
    borrow_in = bi;
    start = 1'b1;
  endtask

  initial begin
    int nd;
    n_rst = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    borrow_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst diff", diff, 0);
    chk("rst underflow", underflow, 0);
    n_rst = 1'b1;
    @(negedge clk);

    launch(4'd7, 4'd3, 1'b0);
    wait_done("7-3", 4'd4, 1'b0, 0);
    @(negedge clk);
    chk("7-3 done_pulse", done, 0);
    repeat (3) @(negedge clk);
    chk("idle hold diff", diff, 4);
    chk("idle busy", busy, 0);

    launch(4'd3, 4'd5, 1'b0);
    wait_done("3-5", 4'd14, 1'b1, 0);
    @(negedge clk);
    launch(4'd0, 4'd0, 1'b1);
    wait_done("0-0-1", 4'd15, 1'b1, 0);
    @(negedge clk);
    launch(4'd15, 4'd15, 1'b0);
    wait_done("15-15", 4'd0, 1'b0, 0);
    @(negedge clk);
    launch(4'd8, 4'd1, 1'b1);
    wait_done("8-1-1", 4'd6, 1'b0, 0);
    @(negedge clk);

    // start held, operands churn during SHIFT; relaunch from the DONE cycle
    launch(4'd2, 4'd1, 1'b0);
    wait_done("held", 4'd1, 1'b0, 1);
    launch(4'd4, 4'd6, 1'b0);
    wait_done("held2", 4'd14, 1'b1, 0);
    @(negedge clk);

    // reset on the 2nd SHIFT cycle
    launch(4'd9, 4'd2, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst diff", diff, 0);
    chk("midrst underflow", underflow, 0);
    n_rst = 1'b1;
    nd = 0;
    repeat (8) begin
      @(negedge clk);
      nd += int'(done);
    end
    chk("midrst no_done", nd, 0);
    launch(4'd10, 4'd3, 1'b0);
    wait_done("post_rst", 4'd7, 1'b0, 0);
    @(negedge clk);

    // back-to-back 9-4 then 2-6
    launch(4'd9, 4'd4, 1'b0);
    wait_done("b2b1", 4'd5, 1'b0, 0);
    launch(4'd2, 4'd6, 1'b0);
    wait_done("b2b2", 4'd12, 1'b1, 0);
    @(negedge clk);
    chk("b2b done_pulse", done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
